// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the VGA Tetris screen-mode controller.
//   - MODE_* : encoding of the mode output (READY / PLAY / OVER)
//   - state_t: screen-mode state type, encoded identically to the mode output
//   - DEF_*  : default debounce and frame-count constants
//   - cnt_width(): width of a counter that must hold 0 .. n-1
// -----------------------------------------------------------------------------
package tetris_pkg;

  localparam logic [1:0] MODE_READY = 2'd0;
  localparam logic [1:0] MODE_PLAY  = 2'd1;
  localparam logic [1:0] MODE_OVER  = 2'd2;

  typedef enum logic [1:0] {
    ST_READY = MODE_READY,
    ST_PLAY  = MODE_PLAY,
    ST_OVER  = MODE_OVER
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000; // 20 ms at 50 MHz
  localparam int DEF_BLINK_FRAMES    = 30;
  localparam int DEF_OVER_FRAMES     = 180;

  // A counter running 0 .. n-1 needs $clog2(n) bits; never return zero width.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tetris_screen_sequencer_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises a raw active-low push button and accepts a new level only after
// DEBOUNCE_CYCLES consecutive synchronised samples that differ from the
// currently accepted level. The accepted level comes out of reset released (1).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_n        raw button, active-low, asynchronous to clk
//   start_press  one-cycle pulse on each accepted released->pressed change
// -----------------------------------------------------------------------------
module key_debounce
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic start_press
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;   // [0] first flop, [1] metastability-safe sample
  logic          level_q;  // accepted (debounced) key level
  logic [CW-1:0] cnt_q;    // consecutive samples disagreeing with level_q

  // NOTE: every register in a clocked block is assigned with <=, so all flops
  // sample the pre-edge values of each other and simulation matches hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      level_q     <= 1'b1;
      cnt_q       <= '0;
      start_press <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_n};
      start_press <= 1'b0;
      if (sync_q[1] == level_q) begin
        // Any agreeing sample breaks the run of differing samples.
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q       <= '0;
        level_q     <= sync_q[1];
        // A change away from level 1 is a press; the release edge is silent.
        start_press <= level_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/tetris_screen_sequencer.sv
// -----------------------------------------------------------------------------
// tetris_screen_sequencer
// Screen-mode controller for the VGA Tetris display: READY (start screen),
// PLAY and OVER. Mode changes are taken only on frame_start so a frame never
// mixes content from two modes. The start-screen image blinks with a
// half-period of BLINK_FRAMES frames while in READY.
//
// Optional build macro ATTRACT_TIMEOUT_EN: when defined, OVER returns to READY
// by itself after OVER_FRAMES frames (a start press still returns earlier).
// When undefined, OVER waits for a start press and OVER_FRAMES does not exist.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   key_start_n    raw start button, active-low, asynchronous
//   frame_start    one-cycle pulse at start of vertical blanking
//   game_over      level from game logic, 1 = game lost
//   ready_sig      start-screen region enable (READY)
//   gameready_sig  start-screen image visible (READY and blink phase on)
//   play_sig       game renderer enable (PLAY)
//   over_sig       game-over renderer enable (OVER)
//   game_rst_n     active-low one-cycle reset to the game logic on READY->PLAY
//   mode           current mode: 0 READY, 1 PLAY, 2 OVER
// -----------------------------------------------------------------------------
module tetris_screen_sequencer
  import tetris_pkg::*;
#(
`ifdef ATTRACT_TIMEOUT_EN
  parameter int OVER_FRAMES     = DEF_OVER_FRAMES,
`endif
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BLINK_FRAMES    = DEF_BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       frame_start,
  input  logic       game_over,
  output logic       ready_sig,
  output logic       gameready_sig,
  output logic       play_sig,
  output logic       over_sig,
  output logic       game_rst_n,
  output logic [1:0] mode
);

  localparam int            BW         = cnt_width(BLINK_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic start_press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_start_n),
    .start_press(start_press)
  );

  state_t        state_q, state_d;
  logic          start_pend_q, start_pend_d;
  logic          over_pend_q, over_pend_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          over_timeout;

`ifdef ATTRACT_TIMEOUT_EN
  localparam int            OW        = cnt_width(OVER_FRAMES);
  localparam logic [OW-1:0] OVER_LAST = OW'(OVER_FRAMES - 1);

  logic [OW-1:0] over_cnt_q, over_cnt_d;

  assign over_timeout = frame_start && (over_cnt_q == OVER_LAST);
`else
  assign over_timeout = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    start_pend_d  = start_pend_q;
    over_pend_d   = 1'b0;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
`ifdef ATTRACT_TIMEOUT_EN
    over_cnt_d    = over_cnt_q;
`endif

    case (state_q)
      ST_READY: begin
        // start_pend is registered, so a press arriving together with
        // frame_start only takes effect at the following frame_start.
        if (frame_start && start_pend_q) begin
          state_d      = ST_PLAY;
          start_pend_d = 1'b0;
        end else begin
          if (start_press) start_pend_d = 1'b1;
          if (frame_start) begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d   = '0;
              blink_phase_d = ~blink_phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BW'(1);
            end
          end
        end
      end

      ST_PLAY: begin
        // Presses are meaningless mid-game; game_over is only sampled once
        // the state register already reads PLAY, guaranteeing a full frame.
        start_pend_d = 1'b0;
        if (frame_start && over_pend_q) begin
          state_d    = ST_OVER;
`ifdef ATTRACT_TIMEOUT_EN
          over_cnt_d = '0;
`endif
        end else begin
          over_pend_d = over_pend_q | game_over;
        end
      end

      ST_OVER: begin
        if (frame_start && (start_pend_q || over_timeout)) begin
          state_d       = ST_READY;
          start_pend_d  = 1'b0;
          blink_cnt_d   = '0;
          blink_phase_d = 1'b1;
        end else begin
          if (start_press) start_pend_d = 1'b1;
`ifdef ATTRACT_TIMEOUT_EN
          if (frame_start) over_cnt_d = over_cnt_q + OW'(1);
`endif
        end
      end

      default: begin
        state_d      = ST_READY;
        start_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_READY;
      start_pend_q  <= 1'b0;
      over_pend_q   <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
`ifdef ATTRACT_TIMEOUT_EN
      over_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      start_pend_q  <= start_pend_d;
      over_pend_q   <= over_pend_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
`ifdef ATTRACT_TIMEOUT_EN
      over_cnt_q    <= over_cnt_d;
`endif
    end
  end

  // Outputs are decoded from the next state into their own flops so they
  // change on the same edge as state_q and are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_sig     <= 1'b1;
      gameready_sig <= 1'b1;
      play_sig      <= 1'b0;
      over_sig      <= 1'b0;
      game_rst_n    <= 1'b0;
      mode          <= MODE_READY;
    end else begin
      ready_sig     <= (state_d == ST_READY);
      gameready_sig <= (state_d == ST_READY) && blink_phase_d;
      play_sig      <= (state_d == ST_PLAY);
      over_sig      <= (state_d == ST_OVER);
      game_rst_n    <= !((state_q == ST_READY) && (state_d == ST_PLAY));
      mode          <= state_d;
    end
  end

endmodule

// File: doc/tetris_screen_sequencer.md
Name: tetris_screen_sequencer

Overview:
Top-level screen-mode controller for the VGA Tetris display. Sequences READY (start screen), PLAY and OVER modes from a debounced start key and the game-logic game_over flag. Drives the enables consumed by the start-screen ROM renderer, game renderer and game-over renderer. All mode changes are deferred to the frame boundary so no frame shows mixed content. Blinks the start-screen image at a fixed frame period.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a key level (20 ms at 50 MHz)
BLINK_FRAMES, 30, frames per blink half-period in READY
OVER_FRAMES, 180, frames in OVER before auto-return (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_start_n  in  1  raw start button, active-low, asynchronous to clk
frame_start  in  1  single-cycle pulse at start of vertical blanking
game_over  in  1  level from game logic; high = game lost
ready_sig  out  1  start-screen region enable
gameready_sig  out  1  start-screen image visible (blink phase)
play_sig  out  1  game renderer enable
over_sig  out  1  game-over renderer enable
game_rst_n  out  1  active-low one-cycle reset pulse to game logic
mode  out  2  current state: 0 READY, 1 PLAY, 2 OVER

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. During reset: state=READY, ready_sig=1, gameready_sig=1, play_sig=0, over_sig=0, game_rst_n=0, mode=0. All pending flags and counters are 0. game_rst_n goes to 1 on the first clk edge after reset release. Reset mid-frame is legal and forces READY immediately.
- Key path: key_debounce (see Decomposition) produces start_press, a one-cycle pulse on each accepted released->pressed transition.
- start_pend: set by start_press in READY or OVER; ignored and held 0 in PLAY. Cleared when the transition it triggered is taken.
- over_pend: set when game_over=1 in PLAY; cleared on leaving PLAY.
- Transitions are evaluated only in a cycle where frame_start=1:
  - READY to PLAY if start_pend. game_rst_n=0 for exactly the cycle after the transition edge.
  - PLAY to OVER if over_pend.
  - OVER to READY if start_pend.
  - Otherwise the state holds.
- If start_press and frame_start occur in the same cycle, the press is latched and acts at the next frame_start, not the current one.
- Outputs are registered and decoded from state:
  - ready_sig=1 only in READY.
  - play_sig=1 only in PLAY.
  - over_sig=1 only in OVER.
  - gameready_sig = READY AND blink_phase.
  - mode=state.
- Blink:
  - On entering READY: blink_cnt=0, blink_phase=1.
  - In READY, each frame_start increments blink_cnt.
  - At BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
  - The counter is frozen outside READY.
- Counter widths come from $clog2 of the parameter. No wrap-around occurs beyond the defined terminal values.
- If game_over is already high when entering PLAY, the transition to OVER waits at least one full frame: over_pend is sampled only from the first cycle after entry.

Optional Feature:
Macro ATTRACT_TIMEOUT_EN.
- Defined: in OVER, over_cnt counts frame_start pulses. When it reaches OVER_FRAMES-1 at a frame_start, the block returns to READY without a key press. A key press returns to READY earlier. over_cnt resets on entering OVER.
- Undefined: OVER holds until a start press. over_cnt logic and the OVER_FRAMES parameter use are absent.

Decomposition:
- Shared package tetris_pkg holds:
  - mode encoding constants MODE_READY=2'd0, MODE_PLAY=2'd1, MODE_OVER=2'd2;
  - the default frame-count constants.
- One sub-module, key_debounce:
  - 2-FF synchronizer followed by a stability counter; the accepted level resets to 1 (released);
  - the accepted level changes after DEBOUNCE_CYCLES consecutive equal samples;
  - emits a press pulse on the 1-to-0 accepted change.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_FRAMES=2, OVER_FRAMES=3, frame_start every 20 cycles):
- Reset release -> mode=0, ready_sig=1, gameready_sig=1, game_rst_n rises after 1 clk. gameready_sig toggles every 2 frame_starts: 1,1,0,0,1.
- key_start_n held low 10 cycles in READY -> one start_press. At the next frame_start, mode=1, play_sig=1, game_rst_n low for exactly 1 cycle.
- key_start_n bounces (low 2, high 1, low 2) -> no start_press; mode stays 0.
- start_press coincident with frame_start -> mode stays 0 for that frame and becomes 1 at the following frame_start.
- In PLAY, press key and then raise game_over -> key ignored. mode=2 at the next frame_start. A press in OVER returns mode=0 at the next frame_start, with blink restarted at phase 1.
- ATTRACT_TIMEOUT_EN defined, no key in OVER -> mode=0 at the 3rd frame_start after entry. Undefined -> mode stays 2 indefinitely.
